ac_mc: RTL
==========

Name: ac_mc

Overview:
- Multi-channel successor to the single-channel analog comparator digital controller.
- Controls NCH comparator channels from one register bus:
  - per-channel enable with a settling window,
  - 2-flop synchronisation of the analog outputs,
  - programmable glitch filter,
  - edge-select interrupt flags with write-1-to-clear, and a combined irq.
- Sits between the system register bus and NCH analog comparator models.

Parameters:
- ID, 1, value returned by the read-only ID register.
- NCH, 4, number of comparator channels, 1..8.
- SETTLE, 8, cycles after enable before edges are detected, 1..255.
- ADDR_W, 4, register address width; must satisfy 4+NCH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- bus_addr  in  ADDR_W  register address.
- bus_we  in  1  write strobe, single cycle.
- bus_wdata  in  8  write data.
- bus_re  in  1  read strobe, single cycle.
- bus_rdata  out  8  read data, registered.
- acout  in  NCH  raw comparator outputs, asynchronous to clk.
- acenable  out  NCH  per-channel analog enable.
- irq  out  1  OR over channels of (flag & irq-enable).

Behaviour:
- Reset (rst low): all registers 0, channels OFF. Outputs bus_rdata=0, acenable=0, irq=0.
- Register map (8-bit):
  - 0x0 ENABLE, RW, bit c enables channel c.
  - 0x1 STATUS, RO, filtered comparator values.
  - 0x2 IFLAG, W1C.
  - 0x3 ID, RO, ID[7:0].
  - 0x4+c MODE_c, RW: [1:0] edge (00 none, 01 rise, 10 fall, 11 both); [4:2] filter length F; [7] irq enable.
- Bits above NCH in ENABLE, STATUS and IFLAG read 0 and ignore writes. Unmapped addresses read 0 and ignore writes.
- Bus timing:
  - A write takes effect at the clock edge where bus_we=1.
  - A read returns data on bus_rdata one cycle after bus_re. bus_rdata holds until the next read.
  - we and re both high: the write is performed, and the read returns the pre-write value.
- acenable[c] equals ENABLE[c] (registered).
- Per-channel state machine:
  - OFF -> SETTLE when ENABLE[c] goes 0->1. The settle counter loads SETTLE-1.
  - SETTLE: counter decrements each cycle. At 0 the channel goes to RUN, and filt is loaded with sync2 with no edge detected.
  - RUN: filtering and edge detection are active.
  - Any state -> OFF when ENABLE[c]=0, within the same cycle as the write. filt and the filter counter clear to 0. IFLAG is NOT cleared.
  - Rewriting ENABLE[c]=1 while in SETTLE or RUN has no effect.
- Synchroniser: acout -> sync1 -> sync2, always running (including OFF).
- Filter (RUN only):
  - cnt resets to 0 whenever sync2 == filt.
  - While sync2 != filt, cnt increments; when cnt == F, filt toggles and cnt clears.
  - This requires F+1 consecutive differing cycles.
  - Latency from an acout change stable before edge k: filt toggles at edge k+2+F.
- Edge flag: IFLAG[c] sets at the edge where filt toggles, if the toggle direction matches MODE_c.edge. A set and a W1C on the same bit in the same cycle: set wins.
- irq is combinational from IFLAG and MODE_c[7].
- A MODE_c write while in RUN takes effect the next cycle. A new F applies to the count in progress: if cnt already >= new F, toggle on the next differing cycle.
- An asynchronous reset mid-operation returns everything to reset values immediately.

Decomposition:
- Package ac_mc_pkg:
  - register offset localparams (REG_ENABLE, REG_STATUS, REG_IFLAG, REG_ID, REG_MODE0),
  - edge_mode_e enum,
  - chan_state_e enum {OFF, SETTLE, RUN},
  - mode_reg_t packed struct.
- One sub-module, ac_mc_chan:
  - contains the synchroniser, state machine, settle counter, filter and edge detect,
  - generated NCH times.
- The top module holds the register bank, IFLAG and the read mux.

Test Plan:
- Reset: after rst is released, read 0x0..0x7 -> 0,0,0,ID,0,0,0,0; acenable=0; irq=0.
- Channel 0 with MODE0=0x81 (rise, F=0, ie), enable, wait SETTLE=8 cycles, raise acout[0] before edge k -> STATUS[0] and IFLAG[0] set at edge k+2, irq=1. Write IFLAG=0x01 -> irq=0.
- Glitch filter: MODE1=0x92 (fall, F=4), channel in RUN with acout[1]=1.
  - A 4-cycle low pulse -> no change, flag 0.
  - A 5-cycle low pulse -> STATUS[1]=0, IFLAG[1]=1.
- Settling: toggle acout[2] at cycles 1..6 after enable (SETTLE=8) -> no flag. STATUS[2] equals acout[2] after settle.
- Simultaneous events: W1C IFLAG[0] in the same cycle as a new rise event on channel 0 -> IFLAG[0] stays 1.
- Disable mid-SETTLE, then async reset asserted mid-filter count -> acenable=0 immediately, all outputs return to 0. Re-enable restarts the full SETTLE count.

Source files
------------

// File: rtl/ac_mc_pkg.sv
// Shared definitions for the multi-channel analog comparator controller:
// register offsets, mode-register layout and channel state encoding.
package ac_mc_pkg;

  localparam int unsigned REG_ENABLE = 32'd0;
  localparam int unsigned REG_STATUS = 32'd1;
  localparam int unsigned REG_IFLAG  = 32'd2;
  localparam int unsigned REG_ID     = 32'd3;
  localparam int unsigned REG_MODE0  = 32'd4;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RUN    = 2'b10
  } chan_state_e;

  typedef struct packed {
    logic       ie;
    logic [1:0] rsvd;
    logic [2:0] flen;
    edge_mode_e edge_sel;
  } mode_reg_t;

  // True when a filtered transition in the given direction should raise a flag.
  function automatic logic edge_match(edge_mode_e mode, logic rising);
    logic hit;
    case (mode)
      EDGE_NONE: hit = 1'b0;
      EDGE_RISE: hit = rising;
      EDGE_FALL: hit = ~rising;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ac_mc_if.sv
// Register bus between the system and the comparator controller.
interface ac_mc_if #(
  parameter int ADDR_W = 4
) ();

  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [7:0]        wdata;
  logic              re;
  logic [7:0]        rdata;

  modport master (output addr, output we, output wdata, output re, input rdata);
  modport slave  (input addr, input we, input wdata, input re, output rdata);

endinterface

// File: rtl/ac_mc_chan.sv
// One comparator channel: 2-flop synchroniser, OFF/SETTLE/RUN sequencing,
// settle counter, glitch filter and edge-flag request.
module ac_mc_chan
  import ac_mc_pkg::*;
#(
  parameter int SETTLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       acout,
  input  logic       en_nxt,
  input  logic [2:0] flen,
  input  edge_mode_e edge_sel,
  output logic       filt,
  output logic       flag_set
);

  logic        sync1_r;
  logic        sync2_r;
  chan_state_e state_r;
  logic [7:0]  settle_r;
  logic [2:0]  cnt_r;
  logic        filt_r;
  logic        toggle_s;

  // Synchroniser runs in every state so RUN starts from a settled sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= acout;
      sync2_r <= sync2_r ^ (sync2_r ^ sync1_r);
    end
  end

  // en_nxt is the post-write enable, so a disable takes hold on the write edge.
  always_comb begin
    toggle_s = 1'b0;
    if (en_nxt && (state_r == ST_RUN) && (sync2_r != filt_r) && (cnt_r >= flen)) begin
      toggle_s = 1'b1;
    end else begin
      toggle_s = 1'b0;
    end
  end

  // Channel sequencing, settle countdown and glitch filter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_OFF;
      settle_r <= 8'd0;
      cnt_r    <= 3'd0;
      filt_r   <= 1'b0;
    end else if (!en_nxt) begin
      state_r  <= ST_OFF;
      settle_r <= 8'd0;
      cnt_r    <= 3'd0;
      filt_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_r  <= ST_SETTLE;
          settle_r <= 8'(SETTLE - 1);
        end
        ST_SETTLE: begin
          if (settle_r == 8'd0) begin
            state_r <= ST_RUN;
            filt_r  <= sync2_r;
            cnt_r   <= 3'd0;
          end else begin
            settle_r <= settle_r - 8'd1;
          end
        end
        ST_RUN: begin
          if (sync2_r == filt_r) begin
            cnt_r <= 3'd0;
          end else if (toggle_s) begin
            filt_r <= ~filt_r;
            cnt_r  <= 3'd0;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        default: begin
          state_r <= ST_OFF;
        end
      endcase
    end
  end

  assign filt     = filt_r;
  assign flag_set = toggle_s & edge_match(edge_sel, ~filt_r);

endmodule

// File: rtl/ac_mc.sv
// Multi-channel analog comparator controller: register bank, interrupt
// flags, read mux and NCH generated channel instances.
module ac_mc
  import ac_mc_pkg::*;
#(
  parameter int ID     = 1,
  parameter int NCH    = 4,
  parameter int SETTLE = 8,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  ac_mc_if.slave         bus,
  input  logic [NCH-1:0] acout,
  output logic [NCH-1:0] acenable,
  output logic           irq
);

  logic [NCH-1:0] enable_r;
  logic [NCH-1:0] en_nxt_s;
  logic [NCH-1:0] iflag_r;
  logic [NCH-1:0] w1c_s;
  logic [NCH-1:0] set_s;
  logic [NCH-1:0] filt_s;
  logic [NCH-1:0] ie_s;
  mode_reg_t      mode_r [NCH];
  logic [7:0]     rdata_s;
  logic [7:0]     rdata_r;

  // Post-write enable and clear masks seen by the channels on this edge.
  always_comb begin
    en_nxt_s = enable_r;
    w1c_s    = {NCH{1'b0}};
    if (bus.we && (bus.addr == ADDR_W'(REG_ENABLE))) begin
      en_nxt_s = bus.wdata[NCH-1:0];
    end else begin
      en_nxt_s = enable_r;
    end
    if (bus.we && (bus.addr == ADDR_W'(REG_IFLAG))) begin
      w1c_s = bus.wdata[NCH-1:0];
    end else begin
      w1c_s = {NCH{1'b0}};
    end
  end

  // Enable and flag registers; a flag set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_r <= {NCH{1'b0}};
      iflag_r  <= {NCH{1'b0}};
    end else begin
      enable_r <= en_nxt_s;
      iflag_r  <= (iflag_r & ~w1c_s) | set_s;
    end
  end

  // Per-channel mode registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        mode_r[c] <= mode_reg_t'(8'h00);
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.we && (bus.addr == ADDR_W'(REG_MODE0 + c))) begin
          mode_r[c] <= mode_reg_t'(bus.wdata);
        end
      end
    end
  end

  // Read mux over the current register contents (pre-write on a same-cycle write).
  always_comb begin
    rdata_s = 8'h00;
    if (bus.addr == ADDR_W'(REG_ENABLE)) begin
      rdata_s = 8'(enable_r);
    end else if (bus.addr == ADDR_W'(REG_STATUS)) begin
      rdata_s = 8'(filt_s);
    end else if (bus.addr == ADDR_W'(REG_IFLAG)) begin
      rdata_s = 8'(iflag_r);
    end else if (bus.addr == ADDR_W'(REG_ID)) begin
      rdata_s = 8'(ID);
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.addr == ADDR_W'(REG_MODE0 + c)) begin
          rdata_s = mode_r[c];
        end else begin
          rdata_s = rdata_s;
        end
      end
    end
  end

  // Read data holds until the next read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= 8'h00;
    end else if (bus.re) begin
      rdata_r <= rdata_s;
    end
  end

  // Gather the interrupt enables out of the mode registers.
  always_comb begin
    ie_s = {NCH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      ie_s[c] = mode_r[c].ie;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    ac_mc_chan #(
      .SETTLE (SETTLE)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .acout    (acout[c]),
      .en_nxt   (en_nxt_s[c]),
      .flen     (mode_r[c].flen),
      .edge_sel (mode_r[c].edge_sel),
      .filt     (filt_s[c]),
      .flag_set (set_s[c])
    );
  end

  assign bus.rdata = rdata_r;
  assign acenable  = enable_r;
  assign irq       = |(iflag_r & ie_s);

endmodule
